// File: rtl/seg_dec_display.sv
// Decimal 7-segment driver: captures a binary value on load, converts it to BCD with a
// bit-serial double-dabble engine and updates the registered display atomically on completion.
module seg_dec_display #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DIGITS   = 2,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SEG_W = 7 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_bin;
    logic [DATA_W-1:0]  w_bin_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ovf_acc;
    logic               w_ovf_acc_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_overflow;
    logic               w_overflow_nxt;
    logic [SEG_W-1:0]   r_seg;
    logic [SEG_W-1:0]   w_seg_nxt;
    logic [SEG_W-1:0]   w_disp;
    int                 w_top;

    // Active-low g..a pattern for one BCD digit; out-of-range nibbles go dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000011;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Per-nibble add-3 correction ahead of the shift.
    always_comb begin
        w_bcd_adj = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            w_bcd_adj[4*k +: 4] = add3(r_bcd[4*k +: 4]);
        end
    end

    // Display image from the finished BCD register: dashes on overflow, optional blanking.
    always_comb begin
        w_top  = 0;
        w_disp = '1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_bcd[4*k +: 4] != 4'd0) begin
                w_top = k;
            end
        end
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_ovf_acc) begin
                w_disp[7*k +: 7] = SEG_DASH;
            end else if (BLANK_LZ && (k > w_top)) begin
                w_disp[7*k +: 7] = SEG_BLANK;
            end else begin
                w_disp[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bin_nxt      = r_bin;
        w_bcd_nxt      = r_bcd;
        w_cnt_nxt      = r_cnt;
        w_ovf_acc_nxt  = r_ovf_acc;
        w_seg_nxt      = r_seg;
        w_overflow_nxt = r_overflow;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_bin_nxt     = data_in;
                    w_bcd_nxt     = '0;
                    w_cnt_nxt     = CNT_W'(DATA_W);
                    w_ovf_acc_nxt = 1'b0;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {w_bcd_nxt, w_bin_nxt} = {w_bcd_adj, r_bin} << 1;
                // A carry out of the top digit means the value needs more digits than we drive.
                if (w_bcd_adj[BCD_W-1]) begin
                    w_ovf_acc_nxt = 1'b1;
                end
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_seg_nxt      = w_disp;
                w_overflow_nxt = r_ovf_acc;
                w_done_nxt     = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_acc  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_seg      <= '1;
        end else begin
            r_state    <= w_state_nxt;
            r_bin      <= w_bin_nxt;
            r_bcd      <= w_bcd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf_acc  <= w_ovf_acc_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_overflow <= w_overflow_nxt;
            r_seg      <= w_seg_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign seg_out  = r_seg;

endmodule
